pwm_dac4: RTL and testbench
===========================

// Module: pwm_dac4
// PURPOSE
//   Downstream of the 4-bit trapezoid wave generator. Converts its 4-bit level
//   sample into a 1-bit PWM stream for an RC-filtered output pin.
//   Each PWM frame has 2**LEVEL_W-1 slots. Level N gives N high slots, so
//   level 0 is 0 % duty and level 15 is 100 % duty.
//   Level and prescale are sampled once per frame, which keeps the output
//   glitch-free while the generator ramps.
// PARAMETERS
//   LEVEL_W  4   width of level input; NSLOT = 2**LEVEL_W-1 slots per frame (15)
//   PRESC_W  16  width of prescale input (clk cycles per slot)
// PORTS
//   clk          in   1        system clock
//   rst_n        in   1        async reset, active low
//   enable       in   1        run/stop; low forces idle
//   level        in   LEVEL_W  sample from the wave generator (its wave_out)
//   prescale     in   PRESC_W  clk cycles per slot; 0 is treated as 1
//   pwm_out      out  1        registered PWM output
//   frame_start  out  1        1-cycle pulse on the first cycle of each frame
//   level_q      out  LEVEL_W  level value used by the current frame
// BEHAVIOUR
//   Clocking and reset
//   - Single clock domain. Reset is asynchronous and active-low, named rst_n.
//     Reset is released synchronously by the system.
//   - Reset values: pwm_out=0, frame_start=0, level_q=0.
//     Internal counters are also 0: slot=0, pcnt=0, presc_q=1, running=0.
//   Enable
//   - enable=0: running=0, pwm_out=0, frame_start=0, slot=0, pcnt=0.
//     level_q holds its value.
//   - Frame load: occurs on the first edge with enable=1 and running=0, and at
//     every frame wrap. At a load edge:
//     - level_q <= level
//     - presc_q <= (prescale==0) ? 1 : prescale
//     - pcnt <= presc_q_new-1
//     - slot <= 0
//     - frame_start <= 1
//     - pwm_out <= (level != 0)
//     - running <= 1
//   Slot timing (edges that are not loads)
//   - frame_start <= 0.
//   - If pcnt != 0: pcnt <= pcnt-1.
//   - Else, when pcnt==0 (slot end):
//     - slot < NSLOT-1: slot <= slot+1, pcnt <= presc_q-1,
//       pwm_out <= (slot+1 < level_q).
//     - slot == NSLOT-1: frame wrap, i.e. a load as above on this same edge.
//   Invariants
//   - pwm_out always equals (slot < level_q) for the registered slot, so it
//     changes only at slot boundaries.
//   - Frame length is exactly NSLOT*presc_q cycles.
//   - High time is exactly level_q*presc_q cycles, contiguous from frame start.
//   Boundary conditions
//   - level or prescale changing mid-frame has no effect until the next frame
//     load.
//   - level=15: pwm_out stays 1 across frame wraps with no 1-cycle dip.
//   - level=0: pwm_out stays 0.
//   - prescale=0 behaves identically to prescale=1: one slot per clk, 15-cycle
//     frame.
//   - enable falling mid-frame: pwm_out=0 on the next edge. The frame is
//     abandoned; re-enable starts a fresh frame with a new load.
//   - rst_n asserted mid-frame: all outputs go to reset values immediately
//     (asynchronously).
//   Arithmetic
//   - pcnt is PRESC_W bits and never underflows: it reloads at 0.
//   - slot is LEVEL_W bits and wraps at NSLOT-1, never reaching 2**LEVEL_W-1.
// TESTING
//   1. rst_n=0, enable=0, then release -> pwm_out=0, frame_start=0, level_q=0;
//      they stay so while enable=0.
//   2. enable=1, prescale=2, level=5 -> frame_start pulses every 30 cycles;
//      pwm_out high 10 cycles, low 20; level_q=5.
//   3. level=15, prescale=1 across 3 frames -> pwm_out constantly 1.
//      level=0 -> constantly 0. Frame length is 15 cycles in both cases.
//   4. prescale=3, level=4; change level to 9 at cycle 7 -> current frame keeps
//      12 high / 33 low; next frame gives 27 high / 18 low; level_q=9 from its
//      frame_start.
//   5. Drop enable at cycle 5 of a frame, hold low 10 cycles, raise again ->
//      pwm_out=0 on the next edge; frame_start on the first enabled edge;
//      full 15-slot frame follows.
//   6. prescale=0, level=7 -> identical to prescale=1 (7 high / 8 low).
//      Assert rst_n low mid-frame -> outputs 0 without waiting for clk.

Source files
------------

// File: rtl/pwm_dac4.sv
// pwm_dac4: converts a level sample into a PWM stream with 2**LEVEL_W-1 slots per frame
// Ports:
//   clk, rst_n   clock and async active-low reset
//   enable       run/stop; low forces idle and abandons the current frame
//   level        level sample, captured once per frame
//   prescale     clk cycles per slot, captured once per frame (0 acts as 1)
//   pwm_out      registered PWM output, high for the first level_q slots
//   frame_start  one-cycle pulse on the first cycle of each frame
//   level_q      level used by the current frame
module pwm_dac4 #(
  parameter int LEVEL_W = 4,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  input  logic [PRESC_W-1:0] prescale,
  output logic               pwm_out,
  output logic               frame_start,
  output logic [LEVEL_W-1:0] level_q
);
  localparam logic [LEVEL_W-1:0] LAST = LEVEL_W'(2**LEVEL_W - 2);
  logic [LEVEL_W-1:0] slot_q, slot_d, level_d, slot_nx;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d, presc_q, presc_d, presc_new;
  logic running_q, running_d, pwm_q, pwm_d, fs_q, fs_d, load, slot_end;
  // A load both starts a frame from idle and wraps on the last slot's final cycle,
  // so level 15 stays high across the wrap without a dip.
  always_comb begin
    slot_end  = pcnt_q == '0;
    load      = enable && (!running_q || (slot_end && slot_q == LAST));
    presc_new = (prescale == '0) ? PRESC_W'(1) : prescale;
    slot_nx   = slot_q + 1'b1;
    running_d = enable;
    fs_d      = load;
    level_d   = load ? level : level_q;
    presc_d   = load ? presc_new : presc_q;
    slot_d    = (!enable || load) ? '0 : slot_end ? slot_nx : slot_q;
    pcnt_d    = !enable ? '0 : load ? presc_new - 1'b1 : slot_end ? presc_q - 1'b1 : pcnt_q - 1'b1;
    pwm_d     = !enable ? 1'b0 : load ? (level != '0) : slot_end ? (slot_nx < level_q) : pwm_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      pcnt_q    <= '0;
      presc_q   <= PRESC_W'(1);
      running_q <= 1'b0;
      pwm_q     <= 1'b0;
      fs_q      <= 1'b0;
      level_q   <= '0;
    end else begin
      slot_q    <= slot_d;
      pcnt_q    <= pcnt_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      pwm_q     <= pwm_d;
      fs_q      <= fs_d;
      level_q   <= level_d;
    end
  end
  assign pwm_out     = pwm_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_pwm_dac4.sv
// tb_pwm_dac4: directed self-checking bench for pwm_dac4
module tb_pwm_dac4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [3:0] level = 4'd9;
  logic [15:0] prescale = 16'd5;
  logic pwm_out, frame_start;
  logic [3:0] level_q;
  int total = 0;
  int bad = 0;
  pwm_dac4 dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .level(level), .prescale(prescale),
    .pwm_out(pwm_out), .frame_start(frame_start), .level_q(level_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag, input logic [3:0] lq);
    chk({tag, " pwm"}, 16'(pwm_out), 16'd0);
    chk({tag, " fs"}, 16'(frame_start), 16'd0);
    chk({tag, " lvlq"}, 16'(level_q), 16'(lq));
  endtask
  task automatic restart(input logic [3:0] l, input logic [15:0] p);
    enable = 1'b0;
    @(negedge clk);
    level = l;
    prescale = p;
    enable = 1'b1;
    @(negedge clk);
  endtask
  // Checks one frame cycle by cycle; entered on the sample after the load edge.
  task automatic frame(input int len, input int hi, input logic [3:0] lq, input int chg_at, input logic [3:0] nl);
    for (int k = 0; k < len; k++) begin
      chk($sformatf("fs L%0d H%0d k%0d", len, hi, k), 16'(frame_start), 16'(k == 0));
      chk($sformatf("pwm L%0d H%0d k%0d", len, hi, k), 16'(pwm_out), 16'(k < hi));
      chk($sformatf("lvlq L%0d H%0d k%0d", len, hi, k), 16'(level_q), 16'(lq));
      if (k == chg_at) level = nl;
      @(negedge clk);
    end
  endtask
  initial begin
    #1_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    idle_chk("reset", 4'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_chk("disabled", 4'd0);
    end
    restart(4'd5, 16'd2);
    repeat (2) frame(30, 10, 4'd5, -1, 4'd0);
    restart(4'd15, 16'd1);
    repeat (3) frame(15, 15, 4'd15, -1, 4'd0);
    restart(4'd0, 16'd1);
    repeat (3) frame(15, 0, 4'd0, -1, 4'd0);
    restart(4'd4, 16'd3);
    frame(45, 12, 4'd4, 7, 4'd9);
    frame(45, 27, 4'd9, -1, 4'd0);
    restart(4'd7, 16'd1);
    for (int k = 0; k <= 5; k++) begin
      chk($sformatf("pre-drop pwm k%0d", k), 16'(pwm_out), 16'(k < 7));
      if (k < 5) @(negedge clk);
    end
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      idle_chk("dropped", 4'd7);
    end
    level = 4'd3;
    enable = 1'b1;
    @(negedge clk);
    repeat (2) frame(15, 3, 4'd3, -1, 4'd0);
    restart(4'd7, 16'd0);
    repeat (2) frame(15, 7, 4'd7, -1, 4'd0);
    chk("pre-reset pwm", 16'(pwm_out), 16'd1);
    #2 rst_n = 1'b0;
    #1 idle_chk("async reset", 4'd0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("post reset", 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
